// File: rtl/delivery_velocity_timer.sv
// rtl/delivery_velocity_timer.sv - map step timer with a latched velocity level and update-request handshake
module delivery_velocity_timer #(
    parameter int unsigned STEP_BASE    = 12500000,
    parameter int unsigned UPDATE_STEPS = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        enable,
    input  logic        get_velocity,
    input  logic [1:0]  velocity_sel,
    output logic [1:0]  velocity,
    output logic        velocity_ready,
    output logic        step_tick,
    output logic [15:0] distance,
    output logic [1:0]  estado
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        READY = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [31:0] r_tick;
    logic [7:0]  r_upd;
    logic [1:0]  r_velocity;
    logic        r_ready;
    logic [15:0] r_distance;

    logic [31:0] w_interval;
    logic        w_tick_end;
    logic        w_upd_done;
    logic        w_count;
    logic        w_step;
    logic        w_load;
    logic        w_wipe;

    // Faster levels halve the interval each time; a shift keeps this multiplier-free.
    assign w_interval = 32'(STEP_BASE) >> r_velocity;
    assign w_tick_end = (r_tick == w_interval - 32'd1);
    assign w_upd_done = ((r_upd + 8'd1) == 8'(UPDATE_STEPS));

    always_comb begin
        w_next_state = r_state;
        w_count      = 1'b0;
        w_step       = 1'b0;
        w_load       = 1'b0;
        w_wipe       = 1'b0;
        if (clear) begin
            w_wipe       = 1'b1;
            w_next_state = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (get_velocity) begin
                        w_load       = 1'b1;
                        w_next_state = RUN;
                    end
                end
                RUN, READY: begin
                    // A fetch outranks a coinciding step so the new level starts from a clean count.
                    if (get_velocity) begin
                        w_load       = 1'b1;
                        w_next_state = RUN;
                    end else if (enable) begin
                        w_count = 1'b1;
                        if (w_tick_end) begin
                            w_step = 1'b1;
                            if (r_state == RUN && w_upd_done) begin
                                w_next_state = READY;
                            end
                        end
                    end
                end
                default: begin
                    w_wipe       = 1'b1;
                    w_next_state = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_tick     <= 32'd0;
            r_upd      <= 8'd0;
            r_velocity <= 2'd0;
            r_ready    <= 1'b0;
            r_distance <= 16'd0;
        end else begin
            r_state <= w_next_state;
            if (w_wipe) begin
                r_tick     <= 32'd0;
                r_upd      <= 8'd0;
                r_velocity <= 2'd0;
                r_ready    <= 1'b0;
                r_distance <= 16'd0;
            end else if (w_load) begin
                r_velocity <= velocity_sel;
                r_tick     <= 32'd0;
                r_upd      <= 8'd0;
                r_ready    <= 1'b0;
            end else if (w_count) begin
                if (w_step) begin
                    r_tick <= 32'd0;
                    if (r_distance != 16'hFFFF) begin
                        r_distance <= r_distance + 16'd1;
                    end
                    if (r_state == RUN) begin
                        if (w_upd_done) begin
                            r_ready <= 1'b1;
                            r_upd   <= 8'd0;
                        end else begin
                            r_upd <= r_upd + 8'd1;
                        end
                    end
                end else begin
                    r_tick <= r_tick + 32'd1;
                end
            end
        end
    end

    assign velocity       = r_velocity;
    assign velocity_ready = r_ready;
    assign step_tick      = w_step;
    assign distance       = r_distance;
    assign estado         = r_state;

endmodule

// File: tb/tb_delivery_velocity_timer.sv
// tb/tb_delivery_velocity_timer.sv - scoreboard bench for delivery_velocity_timer at STEP_BASE=8, UPDATE_STEPS=3
module tb_delivery_velocity_timer;

    logic        clock;
    logic        reset;
    logic        clear;
    logic        enable;
    logic        get_velocity;
    logic [1:0]  velocity_sel;
    logic [1:0]  velocity;
    logic        velocity_ready;
    logic        step_tick;
    logic [15:0] distance;
    logic [1:0]  estado;

    int total;
    int bad;
    int cyc;
    int exp_q[$];

    delivery_velocity_timer #(
        .STEP_BASE   (8),
        .UPDATE_STEPS(3)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .clear         (clear),
        .enable        (enable),
        .get_velocity  (get_velocity),
        .velocity_sel  (velocity_sel),
        .velocity      (velocity),
        .velocity_ready(velocity_ready),
        .step_tick     (step_tick),
        .distance      (distance),
        .estado        (estado)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Expected step cycles are queued by the scenario tasks; every observed tick consumes one.
    always @(negedge clock) begin
        #2;
        if (exp_q.size() > 0 && exp_q[0] < cyc) begin
            total++;
            bad++;
            $display("FAIL missed_tick cycle: got none, required tick at %0d", exp_q[0]);
            void'(exp_q.pop_front());
        end
        if (step_tick === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_tick: got tick at cycle %0d, required none", cyc);
            end else begin
                int e;
                e = exp_q.pop_front();
                if (cyc !== e) begin
                    bad++;
                    $display("FAIL tick_cycle: got %0d, required %0d", cyc, e);
                end
            end
        end
    end

    task automatic drive(input logic gv, input logic [1:0] sel, input logic en, input logic clr);
        @(negedge clock);
        get_velocity = gv;
        velocity_sel = sel;
        enable       = en;
        clear        = clr;
    endtask

    task automatic test_reset();
        #3;
        total++;
        if ({velocity, velocity_ready, step_tick, distance, estado} !== 22'd0) begin
            bad++;
            $display("FAIL reset_outputs: got %h, required 0", {velocity, velocity_ready, step_tick, distance, estado});
        end
        @(negedge clock);
        reset = 1'b0;
        repeat (6) drive(1'b0, 2'd3, 1'b1, 1'b0);
        drive(1'b0, 2'd3, 1'b0, 1'b0);
        total++;
        if (estado !== 2'd0 || distance !== 16'd0) begin
            bad++;
            $display("FAIL idle_after_reset: got estado=%0d distance=%0d, required 0 0", estado, distance);
        end
    endtask

    task automatic test_request();
        int t0;
        drive(1'b1, 2'd2, 1'b0, 1'b0);
        drive(1'b0, 2'd2, 1'b1, 1'b0);
        t0 = cyc;
        exp_q.push_back(t0 + 1);
        exp_q.push_back(t0 + 3);
        exp_q.push_back(t0 + 5);
        repeat (5) drive(1'b0, 2'd2, 1'b1, 1'b0);
        drive(1'b0, 2'd2, 1'b0, 1'b0);
        total++;
        if (distance !== 16'd3 || velocity_ready !== 1'b1 || estado !== 2'd2 || velocity !== 2'd2) begin
            bad++;
            $display("FAIL request: got dist=%0d rdy=%0b st=%0d vel=%0d, required 3 1 2 2",
                     distance, velocity_ready, estado, velocity);
        end
    endtask

    task automatic test_handshake();
        int t1;
        repeat (3) drive(1'b0, 2'd3, 1'b0, 1'b0);
        total++;
        if (velocity !== 2'd2 || velocity_ready !== 1'b1) begin
            bad++;
            $display("FAIL sel_ignored: got vel=%0d rdy=%0b, required 2 1", velocity, velocity_ready);
        end
        drive(1'b1, 2'd0, 1'b1, 1'b0);
        drive(1'b0, 2'd0, 1'b1, 1'b0);
        t1 = cyc;
        total++;
        if (velocity_ready !== 1'b0 || velocity !== 2'd0 || estado !== 2'd1) begin
            bad++;
            $display("FAIL handshake: got rdy=%0b vel=%0d st=%0d, required 0 0 1", velocity_ready, velocity, estado);
        end
        exp_q.push_back(t1 + 7);
        repeat (7) drive(1'b0, 2'd0, 1'b1, 1'b0);
        drive(1'b0, 2'd0, 1'b0, 1'b0);
        total++;
        if (distance !== 16'd4 || estado !== 2'd1) begin
            bad++;
            $display("FAIL after_handshake: got dist=%0d st=%0d, required 4 1", distance, estado);
        end
    endtask

    task automatic test_pause();
        int t2;
        repeat (3) drive(1'b0, 2'd0, 1'b1, 1'b0);
        repeat (5) begin
            drive(1'b0, 2'd0, 1'b0, 1'b0);
            #1;
            total++;
            if (step_tick !== 1'b0) begin
                bad++;
                $display("FAIL pause_tick: got %0b, required 0", step_tick);
            end
        end
        drive(1'b0, 2'd0, 1'b1, 1'b0);
        t2 = cyc;
        exp_q.push_back(t2 + 4);
        repeat (4) drive(1'b0, 2'd0, 1'b1, 1'b0);
        drive(1'b0, 2'd0, 1'b0, 1'b0);
        total++;
        if (distance !== 16'd5 || estado !== 2'd1 || velocity_ready !== 1'b0) begin
            bad++;
            $display("FAIL pause_resume: got dist=%0d st=%0d rdy=%0b, required 5 1 0", distance, estado, velocity_ready);
        end
    endtask

    task automatic test_clear();
        drive(1'b1, 2'd3, 1'b1, 1'b1);
        drive(1'b0, 2'd3, 1'b1, 1'b0);
        #1;
        total++;
        if ({velocity, velocity_ready, step_tick, distance, estado} !== 22'd0) begin
            bad++;
            $display("FAIL clear: got %h, required 0", {velocity, velocity_ready, step_tick, distance, estado});
        end
        repeat (10) drive(1'b0, 2'd3, 1'b1, 1'b0);
        drive(1'b0, 2'd3, 1'b0, 1'b0);
        total++;
        if (estado !== 2'd0 || distance !== 16'd0) begin
            bad++;
            $display("FAIL clear_idle: got st=%0d dist=%0d, required 0 0", estado, distance);
        end
    endtask

    task automatic test_collision();
        int t0;
        int t3;
        drive(1'b1, 2'd3, 1'b0, 1'b0);
        drive(1'b0, 2'd3, 1'b1, 1'b0);
        t0 = cyc;
        exp_q.push_back(t0);
        exp_q.push_back(t0 + 1);
        drive(1'b0, 2'd3, 1'b1, 1'b0);
        drive(1'b1, 2'd1, 1'b1, 1'b0);
        #1;
        total++;
        if (step_tick !== 1'b0) begin
            bad++;
            $display("FAIL collision_tick: got %0b, required 0", step_tick);
        end
        drive(1'b0, 2'd1, 1'b1, 1'b0);
        t3 = cyc;
        total++;
        if (distance !== 16'd2 || velocity !== 2'd1 || estado !== 2'd1 || velocity_ready !== 1'b0) begin
            bad++;
            $display("FAIL collision: got dist=%0d vel=%0d st=%0d rdy=%0b, required 2 1 1 0",
                     distance, velocity, estado, velocity_ready);
        end
        exp_q.push_back(t3 + 3);
        repeat (3) drive(1'b0, 2'd1, 1'b1, 1'b0);
        drive(1'b0, 2'd1, 1'b0, 1'b0);
        total++;
        if (distance !== 16'd3 || velocity_ready !== 1'b0 || estado !== 2'd1) begin
            bad++;
            $display("FAIL collision_counters: got dist=%0d rdy=%0b st=%0d, required 3 0 1",
                     distance, velocity_ready, estado);
        end
    endtask

    task automatic test_reset_ready();
        int t4;
        drive(1'b1, 2'd3, 1'b0, 1'b0);
        drive(1'b0, 2'd3, 1'b1, 1'b0);
        t4 = cyc;
        for (int i = 0; i < 5; i++) exp_q.push_back(t4 + i);
        repeat (4) drive(1'b0, 2'd3, 1'b1, 1'b0);
        #3;
        total++;
        if (velocity_ready !== 1'b1 || estado !== 2'd2 || step_tick !== 1'b1 || distance !== 16'd7) begin
            bad++;
            $display("FAIL pre_reset_ready: got rdy=%0b st=%0d tick=%0b dist=%0d, required 1 2 1 7",
                     velocity_ready, estado, step_tick, distance);
        end
        reset = 1'b1;
        #1;
        total++;
        if ({velocity, velocity_ready, step_tick, distance, estado} !== 22'd0) begin
            bad++;
            $display("FAIL async_reset: got %h, required 0", {velocity, velocity_ready, step_tick, distance, estado});
        end
        drive(1'b0, 2'd3, 1'b1, 1'b0);
        reset = 1'b0;
        repeat (4) drive(1'b0, 2'd3, 1'b1, 1'b0);
        total++;
        if (estado !== 2'd0 || distance !== 16'd0) begin
            bad++;
            $display("FAIL idle_after_rearm: got st=%0d dist=%0d, required 0 0", estado, distance);
        end
    endtask

    initial begin
        total        = 0;
        bad          = 0;
        cyc          = 0;
        reset        = 1'b1;
        clear        = 1'b0;
        enable       = 1'b0;
        get_velocity = 1'b0;
        velocity_sel = 2'd0;
        test_reset();
        test_request();
        test_handshake();
        test_pause();
        test_clear();
        test_collision();
        test_reset_ready();
        drive(1'b0, 2'd0, 1'b0, 1'b0);
        #3;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL pending_ticks: got %0d outstanding, required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
